// File: rtl/rom_fetch_unit.sv
// ROM instruction fetch unit: drives the external program ROM with a
// programmable number of wait states, buffers fetched words in a 2-entry
// prefetch queue and hands them to the core over a valid/ready handshake.
// A redirect flushes the queue, aborts any in-flight access and restarts
// fetching at the new address.
module rom_fetch_unit #(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              instr_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              ROM_CE,
  output logic              ROM_OE
);

  localparam logic [2:0] WaitInit = 3'(WAIT_STATES);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e            r_state;
  logic [2:0]        r_wait_cnt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_rom_ce_n;
  logic              r_rom_oe_n;

  // Prefetch queue: two slots, read/write pointers and occupancy.
  logic [DATA_W-1:0] r_q_data [2];
  logic [ADDR_W-1:0] r_q_pc   [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;

  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_count_next;
  logic              w_space;
  logic [ADDR_W-1:0] w_fetch_pc_inc;

  // Handshake and queue bookkeeping for the current cycle.
  always_comb begin
    // A redirect cycle never presents data, so no pop can happen in it.
    instr_valid    = (r_count != 2'd0) && !redirect;
    w_pop          = instr_valid && instr_ready;
    w_push         = (r_state == StAccess) && (r_wait_cnt == 3'd0);
    w_count_next   = r_count + 2'(w_push) - 2'(w_pop);
    w_space        = (w_count_next != 2'd2);
    w_fetch_pc_inc = r_fetch_pc + 1'b1;
  end

  assign instr    = r_q_data[r_rd_ptr];
  assign instr_pc = r_q_pc[r_rd_ptr];
  assign rom_addr = r_rom_addr;
  assign ROM_CE   = r_rom_ce_n;
  assign ROM_OE   = r_rom_oe_n;

  // Fetch FSM, ROM strobes and prefetch queue; reset beats redirect beats normal flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_wait_cnt  <= 3'd0;
      r_fetch_pc  <= RESET_PC;
      r_rom_addr  <= '0;
      r_rom_ce_n  <= 1'b1;
      r_rom_oe_n  <= 1'b1;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_q_data[0] <= '0;
      r_q_data[1] <= '0;
      r_q_pc[0]   <= '0;
      r_q_pc[1]   <= '0;
    end else if (redirect) begin
      // Flush and restart immediately at the new address; in-flight data is dropped.
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_fetch_pc <= redirect_addr;
      r_rom_addr <= redirect_addr;
      r_wait_cnt <= WaitInit;
      r_state    <= StAccess;
      r_rom_ce_n <= 1'b0;
      r_rom_oe_n <= 1'b0;
    end else begin
      if (w_push) begin
        r_q_data[r_wr_ptr] <= rom_data;
        r_q_pc[r_wr_ptr]   <= r_rom_addr;
        r_wr_ptr           <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_next;

      unique case (r_state)
        StIdle: begin
          if (w_space) begin
            r_state    <= StAccess;
            r_rom_addr <= r_fetch_pc;
            r_wait_cnt <= WaitInit;
            r_rom_ce_n <= 1'b0;
            r_rom_oe_n <= 1'b0;
          end
        end
        StAccess: begin
          if (r_wait_cnt != 3'd0) begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
          end else begin
            r_fetch_pc <= w_fetch_pc_inc;
            if (w_space) begin
              // Back-to-back access: strobes stay asserted, address advances.
              r_rom_addr <= w_fetch_pc_inc;
              r_wait_cnt <= WaitInit;
            end else begin
              r_state    <= StIdle;
              r_rom_ce_n <= 1'b1;
              r_rom_oe_n <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Self-checking bench for rom_fetch_unit: directed timing scenarios plus a
// randomized phase. A scoreboard queue holds the instruction addresses the
// core should see next; a monitor pops and compares on every transfer.
module tb_rom_fetch_unit;

  localparam int unsigned WS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_addr = 16'h0000;
  logic        instr_ready = 1'b0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        ROM_CE;
  logic        ROM_OE;

  always #5 clk = ~clk;

  rom_fetch_unit #(
    .ADDR_W     (16),
    .DATA_W     (16),
    .WAIT_STATES(WS),
    .RESET_PC   (16'h0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .instr_ready  (instr_ready),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .ROM_CE       (ROM_CE),
    .ROM_OE       (ROM_OE)
  );

  // ROM contents are addr ^ A5A5; bus shows junk when not enabled.
  assign rom_data = (!ROM_CE && !ROM_OE) ? (rom_addr ^ 16'hA5A5) : 16'hDEAD;

  logic [15:0] exp_q [$];
  logic [15:0] mon_e;
  int          n_pass  = 0;
  int          n_total = 0;
  int          n_xfer  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Expected stream after a reset or redirect: sequential 16-bit addresses.
  task automatic restart(input logic [15:0] a);
    exp_q.delete();
    for (int i = 0; i < 1000; i++) exp_q.push_back(a + 16'(i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller at the start of cycle 0 (first cycle with rst low).
  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    restart(16'h0000);
    step();
    check("rst_next_ce", 32'(ROM_CE), 1);
    check("rst_next_oe", 32'(ROM_OE), 1);
    check("rst_next_valid", 32'(instr_valid), 0);
    step();
    @(negedge clk);
    check("rst_ce", 32'(ROM_CE), 1);
    check("rst_oe", 32'(ROM_OE), 1);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_instr", 32'(instr), 0);
    check("rst_instr_pc", 32'(instr_pc), 0);
    step();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every accepted instruction must match the model stream.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("xfer_pc", 32'(instr_pc), 32'(mon_e));
        check("xfer_data", 32'(instr), 32'(mon_e ^ 16'hA5A5));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int first;
    int prev;
    int ce_low;
    int base;
    int guard;
    int r;

    // Reset, then stream with ready held high.
    do_reset();
    instr_ready = 1'b1;
    first = -1;
    prev  = -1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) step();
      @(negedge clk);
      if (c == 1) begin
        check("t1_addr_c1", 32'(rom_addr), 0);
        check("t1_ce_c1", 32'(ROM_CE), 0);
        check("t1_oe_c1", 32'(ROM_OE), 0);
      end
      if (c == 3) check("t1_addr_c3", 32'(rom_addr), 0);
      if (instr_valid && first < 0) first = c;
      if (instr_valid && instr_ready) begin
        if (prev >= 0) check("t1_gap", 32'(c - prev), WS + 1);
        prev = c;
      end
    end
    check("t1_first_valid", 32'(first), WS + 2);

    // Core stalled: exactly two accesses, then the bus goes idle.
    do_reset();
    instr_ready = 1'b0;
    ce_low = 0;
    for (int c = 0; c < 22; c++) begin
      if (c > 0) step();
      @(negedge clk);
      if (!ROM_CE) ce_low++;
    end
    check("t2_ce_low_cycles", 32'(ce_low), 2 * (WS + 1));
    check("t2_ce_idle", 32'(ROM_CE), 1);
    check("t2_valid_held", 32'(instr_valid), 1);
    check("t2_head_pc", 32'(instr_pc), 0);
    check("t2_head_data", 32'(instr), 32'h0000_A5A5);
    step();
    base = n_xfer;
    instr_ready = 1'b1;
    repeat (12) step();
    check("t2_drain", 32'((n_xfer - base) >= 3), 1);

    // Redirect during the access to address 3 with address 2 still queued.
    do_reset();
    instr_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (c > 0) step();
      if (c == 9) instr_ready = 1'b0;
      if (c == 11) begin
        redirect      = 1'b1;
        redirect_addr = 16'h0010;
        restart(16'h0010);
      end
      if (c == 12) begin
        redirect    = 1'b0;
        instr_ready = 1'b1;
      end
      @(negedge clk);
      if (c == 10) begin
        check("t3_addr3", 32'(rom_addr), 3);
        check("t3_queued_pc", 32'(instr_pc), 2);
      end
      if (c == 11) check("t3_valid_forced_low", 32'(instr_valid), 0);
      if (c == 12) begin
        check("t3_new_addr", 32'(rom_addr), 32'h10);
        check("t3_new_ce", 32'(ROM_CE), 0);
      end
      if (c == 14) check("t3_not_yet_valid", 32'(instr_valid), 0);
      if (c == 15) begin
        check("t3_valid", 32'(instr_valid), 1);
        check("t3_pc", 32'(instr_pc), 32'h10);
      end
    end

    // Redirect to the top of the address space; stream wraps without a gap.
    step();
    redirect      = 1'b1;
    redirect_addr = 16'hFFFF;
    restart(16'hFFFF);
    instr_ready = 1'b1;
    first = -1;
    prev  = -1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step();
      if (c == 1) redirect = 1'b0;
      @(negedge clk);
      if (instr_valid && first < 0) first = c;
      if (instr_valid && instr_ready) begin
        if (prev >= 0) check("t4_gap", 32'(c - prev), WS + 1);
        prev = c;
      end
    end
    check("t4_first_valid", 32'(first), WS + 2);

    // Redirect in a cycle where a transfer would otherwise happen.
    step();
    guard = 0;
    while (!instr_valid && guard < 20) begin
      step();
      guard++;
    end
    check("t5_found_valid", 32'(guard < 20), 1);
    base          = n_xfer;
    redirect      = 1'b1;
    redirect_addr = 16'h1234;
    restart(16'h1234);
    #1;
    check("t5_valid_forced", 32'(instr_valid), 0);
    step();
    redirect = 1'b0;
    check("t5_no_pop", 32'(n_xfer - base), 0);
    repeat (6) step();
    check("t5_delivered", 32'((n_xfer - base) >= 1), 1);

    // Reset in the middle of an access with data queued.
    instr_ready = 1'b0;
    guard = 0;
    while (!(instr_valid && !ROM_CE) && guard < 20) begin
      step();
      guard++;
    end
    check("t6_found_busy", 32'(guard < 20), 1);
    do_reset();
    instr_ready = 1'b1;
    base = n_xfer;
    repeat (10) step();
    check("t6_restart", 32'((n_xfer - base) >= 2), 1);

    // Randomized traffic: random ready, redirects (often near wrap) and resets.
    for (int i = 0; i < 3000; i++) begin
      step();
      redirect    = 1'b0;
      instr_ready = ($urandom_range(0, 99) < 70);
      r = $urandom_range(0, 99);
      if (r < 1) begin
        do_reset();
      end else if (r < 5) begin
        redirect      = 1'b1;
        redirect_addr = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
        restart(redirect_addr);
        @(negedge clk);
        check("rnd_redirect_valid", 32'(instr_valid), 0);
      end
    end
    check("rnd_activity", 32'(n_xfer > 200), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
